// File: rtl/store_write_buffer_pkg.sv
// Shared constants and FSM encoding for the store write buffer.
// STORE_WB_FWD_EN enables store-to-load forwarding from the FIFO.
package store_write_buffer_pkg;

  localparam int RegBus = 32;
  localparam int SelBus = 4;

  localparam logic RstEnable    = 1'b1;
  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WR   = 2'd1,
    WB_RD   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/store_write_buffer_fifo.sv
// Store FIFO: {addr, sel, data} entries, head/next views, match search.
// STORE_WB_FWD_EN adds the youngest-match search port.
module store_write_buffer_fifo
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RegBus,
  parameter int DATA_W = RegBus,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [SelBus-1:0] i_sel,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [SelBus-1:0] o_head_sel,
  output logic [DATA_W-1:0] o_head_data,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic [SelBus-1:0] o_next_sel,
  output logic [DATA_W-1:0] o_next_data,
  output logic [PTR_W:0]    o_count,
  output logic              o_full,
  output logic              o_empty
`ifdef STORE_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] i_m_addr,
  output logic              o_m_hit,
  output logic              o_m_all,
  output logic [DATA_W-1:0] o_m_data
`endif
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [SelBus-1:0] r_sel  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [PTR_W-1:0]  w_nx_ptr;

  assign w_nx_ptr = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_addr[r_wr_ptr] <= i_addr;
        r_sel[r_wr_ptr]  <= i_sel;
        r_data[r_wr_ptr] <= i_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= w_nx_ptr;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_sel  = r_sel[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_next_addr = r_addr[w_nx_ptr];
  assign o_next_sel  = r_sel[w_nx_ptr];
  assign o_next_data = r_data[w_nx_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty     = (r_count == '0);

`ifdef STORE_WB_FWD_EN
  logic [PTR_W-1:0] w_idx;

  // Oldest to youngest; the last hit wins so the youngest store decides.
  always_comb begin
    o_m_hit  = 1'b0;
    o_m_all  = 1'b0;
    o_m_data = '0;
    w_idx    = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < r_count) &&
          (r_addr[w_idx][ADDR_W-1:2] == i_m_addr[ADDR_W-1:2])) begin
        o_m_hit  = 1'b1;
        o_m_all  = &r_sel[w_idx];
        o_m_data = r_data[w_idx];
      end
    end
  end
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Write-through store buffer between data cache and RAM.
// STORE_WB_FWD_EN enables forwarding of full-word stores to loads.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RegBus,
  parameter int DATA_W = RegBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SelBus-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SelBus-1:0] ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i,
  output logic              wb_empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic              r_ram_ce;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [SelBus-1:0] r_ram_sel;
  logic [DATA_W-1:0] r_ram_data;
  logic [DATA_W-1:0] r_cpu_data;
  logic              w_ce_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [SelBus-1:0] w_sel_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  logic              w_store;
  logic              w_load;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_done;
  logic              w_ld_done;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_rd_bypass;
  logic [ADDR_W-1:0] w_head_addr;
  logic [SelBus-1:0] w_head_sel;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_next_addr;
  logic [SelBus-1:0] w_next_sel;
  logic [DATA_W-1:0] w_next_data;
  logic [PTR_W:0]    w_count;
  logic              w_full;
  logic              w_empty;

  assign w_store   = cpu_ce_i & cpu_we_i;
  assign w_load    = cpu_ce_i & ~cpu_we_i;
  assign w_ack     = ram_ack_i & r_ram_ce;
  assign w_push    = w_store & ~w_full;
  assign w_pop     = (r_state == WB_WR) & w_ack;
  assign w_rd_done = (r_state == WB_RD) & w_ack;

`ifdef STORE_WB_FWD_EN
  logic              w_m_hit;
  logic              w_m_all;
  logic [DATA_W-1:0] w_m_data;
  logic              w_fwd;

  assign w_fwd       = w_load & w_m_hit & w_m_all;
  assign w_rd_bypass = w_load & ~w_m_hit;
  assign w_ld_done   = w_rd_done | w_fwd;
  assign w_ld_data   = w_rd_done ? ram_data_i : w_m_data;
`else
  assign w_rd_bypass = 1'b0;
  assign w_ld_done   = w_rd_done;
  assign w_ld_data   = ram_data_i;
`endif

  store_write_buffer_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_addr      (cpu_addr_i),
    .i_sel       (cpu_sel_i),
    .i_data      (cpu_data_i),
    .o_head_addr (w_head_addr),
    .o_head_sel  (w_head_sel),
    .o_head_data (w_head_data),
    .o_next_addr (w_next_addr),
    .o_next_sel  (w_next_sel),
    .o_next_data (w_next_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
`ifdef STORE_WB_FWD_EN
    ,
    .i_m_addr    (cpu_addr_i),
    .o_m_hit     (w_m_hit),
    .o_m_all     (w_m_all),
    .o_m_data    (w_m_data)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = r_ram_ce;
    w_we_nxt    = r_ram_we;
    w_addr_nxt  = r_ram_addr;
    w_sel_nxt   = r_ram_sel;
    w_data_nxt  = r_ram_data;
    unique case (r_state)
      WB_IDLE: begin
        if (w_rd_bypass || (w_empty && w_load)) begin
          w_state_nxt = WB_RD;
          w_ce_nxt    = ChipEnable;
          w_we_nxt    = WriteDisable;
          w_addr_nxt  = cpu_addr_i;
          w_sel_nxt   = cpu_sel_i;
        end else if (!w_empty) begin
          w_state_nxt = WB_WR;
          w_ce_nxt    = ChipEnable;
          w_we_nxt    = WriteEnable;
          w_addr_nxt  = w_head_addr;
          w_sel_nxt   = w_head_sel;
          w_data_nxt  = w_head_data;
        end
      end
      WB_WR: begin
        if (w_ack) begin
          // Back-to-back drain keeps ram_ce_o high.
          if (w_count > (PTR_W+1)'(1)) begin
            w_addr_nxt = w_next_addr;
            w_sel_nxt  = w_next_sel;
            w_data_nxt = w_next_data;
          end else begin
            w_state_nxt = WB_IDLE;
            w_ce_nxt    = ChipDisable;
            w_we_nxt    = WriteDisable;
          end
        end
      end
      WB_RD: begin
        if (w_ack) begin
          w_state_nxt = WB_IDLE;
          w_ce_nxt    = ChipDisable;
          w_we_nxt    = WriteDisable;
        end
      end
      default: begin
        w_state_nxt = WB_IDLE;
        w_ce_nxt    = ChipDisable;
        w_we_nxt    = WriteDisable;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state    <= WB_IDLE;
      r_ram_ce   <= ChipDisable;
      r_ram_we   <= WriteDisable;
      r_ram_addr <= '0;
      r_ram_sel  <= '0;
      r_ram_data <= '0;
      r_cpu_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ram_ce   <= w_ce_nxt;
      r_ram_we   <= w_we_nxt;
      r_ram_addr <= w_addr_nxt;
      r_ram_sel  <= w_sel_nxt;
      r_ram_data <= w_data_nxt;
      if (w_ld_done) begin
        r_cpu_data <= w_ld_data;
      end
    end
  end

  assign stallreq   = (w_store & w_full) | (w_load & ~w_ld_done);
  assign cpu_data_o = w_ld_done ? w_ld_data : r_cpu_data;
  assign ram_ce_o   = r_ram_ce;
  assign ram_we_o   = r_ram_we;
  assign ram_addr_o = r_ram_addr;
  assign ram_sel_o  = r_ram_sel;
  assign ram_data_o = r_ram_data;
  assign wb_empty_o = w_empty & (r_state != WB_WR);

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: program-order memory model plus RAM model.
// Build with or without STORE_WB_FWD_EN.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;
  logic        ram_ack_i = 1'b0;
  logic        wb_empty_o;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq   (stallreq),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i),
    .ram_ack_i  (ram_ack_i),
    .wb_empty_o (wb_empty_o)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t",
                  name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } st_t;

  st_t         pend[$];
  logic [31:0] ram  [int];
  logic [31:0] arch [int];
  logic [31:0] last_load = '0;

  function automatic logic [31:0] dflt(input int w);
    return 32'h5EED_0000 ^ (32'(w) * 32'h0000_9E37);
  endfunction

  function automatic logic [31:0] ram_word(input int w);
    return ram.exists(w) ? ram[w] : dflt(w);
  endfunction

  function automatic logic [31:0] arch_word(input int w);
    return arch.exists(w) ? arch[w] : dflt(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [3:0] s,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  int ack_pct   = 100;
  bit spur      = 1'b0;
  bit force_ack = 1'b0;

  always @(posedge clk) begin
    #1;
    if (force_ack) ram_ack_i = 1'b1;
    else if (ram_ce_o) ram_ack_i = ($urandom_range(0, 99) < ack_pct);
    else ram_ack_i = spur && ($urandom_range(0, 3) == 0);
    if (ram_ce_o && !ram_we_o) ram_data_i = ram_word(int'(ram_addr_o[31:2]));
    else ram_data_i = $urandom;
  end

  bit          c_rd, c_wr, c_st, c_ld, c_fwd, c_match, c_stall;
  logic [31:0] c_ld_val;
  bit          prev_v = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [5:0]  prev_ctl;

  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      arch = ram;
      last_load = '0;
      prev_v = 1'b0;
    end else begin
      c_rd = ram_ce_o && !ram_we_o && ram_ack_i;
      c_wr = ram_ce_o && ram_we_o && ram_ack_i;
      c_st = cpu_ce_i && cpu_we_i;
      c_ld = cpu_ce_i && !cpu_we_i;
      c_ld_val = arch_word(int'(cpu_addr_i[31:2]));
      c_match = 1'b0;
      c_fwd = 1'b0;
      foreach (pend[i])
        if (pend[i].a[31:2] == cpu_addr_i[31:2]) begin
          c_match = 1'b1;
          c_fwd = (pend[i].s == 4'hF);
        end
`ifndef STORE_WB_FWD_EN
      c_fwd = 1'b0;
`endif
      c_fwd = c_fwd && c_ld;
      c_stall = c_st ? (pend.size() == DEPTH) :
                c_ld ? !(c_rd || c_fwd) : 1'b0;
      chk("stallreq", 32'(stallreq), 32'(c_stall));
      chk("wb_empty_o", 32'(wb_empty_o), 32'(pend.size() == 0));
      chk("cpu_data_o", cpu_data_o,
          (c_ld && (c_rd || c_fwd)) ? c_ld_val : last_load);
      if (prev_v) begin
        chk("hold_ctl", {26'b0, ram_ce_o, ram_we_o, ram_sel_o},
            {26'b0, prev_ctl});
        chk("hold_addr", ram_addr_o, prev_addr);
        chk("hold_data", ram_data_o, prev_data);
      end
      if (ram_ce_o && ram_we_o) begin
        if (pend.size() == 0) chk("wr_without_entry", 32'(ram_ce_o), 32'd0);
        else begin
          chk("wr_addr", ram_addr_o, pend[0].a);
          chk("wr_sel", 32'(ram_sel_o), 32'(pend[0].s));
          chk("wr_data", ram_data_o, pend[0].d);
        end
      end
      if (ram_ce_o && !ram_we_o) begin
        chk("rd_for_load", 32'(c_ld), 32'd1);
        chk("rd_addr", ram_addr_o, cpu_addr_i);
        chk("rd_sel", 32'(ram_sel_o), 32'(cpu_sel_i));
`ifdef STORE_WB_FWD_EN
        chk("rd_no_match", 32'(c_match), 32'd0);
`else
        chk("rd_after_drain", 32'(pend.size()), 32'd0);
`endif
      end
      if (c_ld && (c_rd || c_fwd)) last_load = c_ld_val;
      if (c_wr && pend.size() != 0) begin
        ram[int'(pend[0].a[31:2])] =
          merge(ram_word(int'(pend[0].a[31:2])), pend[0].s, pend[0].d);
        void'(pend.pop_front());
      end
      if (c_st && !c_stall) begin
        pend.push_back('{a: cpu_addr_i, s: cpu_sel_i, d: cpu_data_i});
        arch[int'(cpu_addr_i[31:2])] =
          merge(arch_word(int'(cpu_addr_i[31:2])), cpu_sel_i, cpu_data_i);
      end
      prev_v = ram_ce_o && !ram_ack_i;
      prev_ctl = {ram_ce_o, ram_we_o, ram_sel_o};
      prev_addr = ram_addr_o;
      prev_data = ram_data_o;
    end
  end

  task automatic op(input bit we, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output int stalls);
    cpu_ce_i = 1'b1;
    cpu_we_i = we;
    cpu_addr_i = a;
    cpu_sel_i = s;
    cpu_data_i = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      stalls++;
      if (stalls > 300) begin
        chk("op_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_ce_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = wb_empty_o;
    end
    if (!done) chk("drain_timeout", 32'(wb_empty_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          st, tot, n;
  logic [31:0] wdat [10];
  logic [31:0] pw;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_ce", 32'(ram_ce_o), 32'd0);
    chk("rst_ram_we", 32'(ram_we_o), 32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    chk("rst_ram_sel", 32'(ram_sel_o), 32'd0);
    chk("rst_ram_data", ram_data_o, 32'd0);
    chk("rst_cpu_data", cpu_data_o, 32'd0);
    chk("rst_empty", 32'(wb_empty_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    ack_pct = 100;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), st);
      tot += st;
    end
    chk("burst_stalls", 32'(tot), 32'd0);
    drain();
    for (int i = 0; i < 4; i++)
      chk("burst_ram", ram_word(int'(32'h40 + 32'(i))), 32'hA0 + 32'(i));

    ack_pct = 0;
    for (int i = 0; i < 4; i++)
      op(1'b1, 32'h140 + 32'(4*i), 4'hF, 32'hB0 + 32'(i), st);
    cpu_ce_i = 1'b1;
    cpu_we_i = 1'b1;
    cpu_addr_i = 32'h150;
    cpu_sel_i = 4'hF;
    cpu_data_i = 32'hB4;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", 32'(stallreq), 32'd1);
      chk("full_nonempty", 32'(wb_empty_o), 32'd0);
    end
    ack_pct = 100;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!stallreq) break;
    end
    chk("full_release_cycle", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    cpu_ce_i = 1'b0;
    drain();
    chk("full_fifth_ram", ram_word(int'(32'h150 >> 2)), 32'hB4);

    op(1'b1, 32'h200, 4'hF, 32'hDEADBEEF, st);
    op(1'b0, 32'h200, 4'hF, 32'h0, st);
    drain();
    chk("raw_data", cpu_data_o, 32'hDEADBEEF);
    chk("raw_ram", ram_word(int'(32'h200 >> 2)), 32'hDEADBEEF);

`ifdef STORE_WB_FWD_EN
    ack_pct = 0;
`endif
    op(1'b1, 32'h300, 4'hF, 32'h12345678, st);
    op(1'b0, 32'h300, 4'hF, 32'h0, st);
`ifdef STORE_WB_FWD_EN
    chk("fwd_zero_stall", 32'(st), 32'd0);
`endif
    chk("fwd_data", cpu_data_o, 32'h12345678);
    ack_pct = 100;
    drain();

    op(1'b1, 32'h304, 4'b0011, 32'h0000ABCD, st);
    op(1'b0, 32'h304, 4'hF, 32'h0, st);
    chk("partial_stalls", 32'(st > 0), 32'd1);
    pw = dflt(int'(32'h304 >> 2));
    chk("partial_data", cpu_data_o, {pw[31:16], 16'hABCD});

    for (int i = 0; i < 10; i++) begin
      ack_pct = $urandom_range(30, 100);
      wdat[i] = $urandom;
      op(1'b1, 32'h500 + 32'(4*i), 4'hF, wdat[i], st);
    end
    ack_pct = 100;
    drain();
    for (int i = 0; i < 10; i++)
      chk("wrap_ram", ram_word(int'(32'h140 + 32'(i))), wdat[i]);

    ack_pct = 0;
    for (int i = 0; i < 3; i++)
      op(1'b1, 32'h600 + 32'(4*i), 4'hF, 32'hC0 + 32'(i), st);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", 32'(ram_ce_o && ram_we_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ce", 32'(ram_ce_o), 32'd0);
    chk("mid_rst_empty", 32'(wb_empty_o), 32'd1);
    chk("mid_rst_cpu_data", cpu_data_o, 32'd0);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ignored", 32'(ram_ce_o), 32'd0);
    chk("discarded_store", ram_word(int'(32'h600 >> 2)),
        dflt(int'(32'h600 >> 2)));
    @(posedge clk);
    #1;

    spur = 1'b1;
    ack_pct = 100;
    for (int k = 0; k < 300; k++) begin
      if (k % 25 == 0) ack_pct = $urandom_range(20, 100);
      op(1'($urandom_range(0, 1)),
         32'h400 + 32'(4 * $urandom_range(0, 7)),
         ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15)),
         $urandom, st);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    ack_pct = 100;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
